// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port block RAM: sequencer states,
// derived widths and the address range/alignment check used by both ports.
package mem_pkg;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int wa_w(input int depth);
    return $clog2(depth);
  endfunction

  // Misaligned or beyond the last word: any set bit above the word index.
  function automatic logic addr_bad(input logic [63:0] addr, input int wa);
    return (addr[1:0] != 2'b00) || ((addr >> (wa + 2)) != 64'd0);
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset clear sequencer: walks every word once, then parks in IDLE.
module bram_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int CLEAR_EN = 1,
  parameter int WA_W     = wa_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            clr_we,
  output logic [WA_W-1:0] clr_addr,
  output logic            busy
);

  localparam state_t RST_ST = (CLEAR_EN != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [WA_W-1:0] LAST = WA_W'(DEPTH - 1);

  state_t          state, nxt;
  logic [WA_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_ST;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == ST_CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt    = state;
    clr_we = 1'b0;
    busy   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        busy   = 1'b1;
        if (cnt == LAST) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/dp_blockram.sv
// True-dual-port word RAM: port A read/write with byte enables, port B read-only,
// both read-first with a 1- or 2-stage response pipeline per port.
module dp_blockram
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 32,
  parameter int OUT_REG  = 0,
  parameter int CLEAR_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [DATA_W/8-1:0]    a_be,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  output logic                   a_ready,
  output logic                   a_rvalid,
  output logic [DATA_W-1:0]      a_rdata,
  output logic                   a_err,
  input  logic                   b_req,
  input  logic [ADDR_W-1:0]      b_addr,
  output logic                   b_ready,
  output logic                   b_rvalid,
  output logic [DATA_W-1:0]      b_rdata,
  output logic                   b_err,
  output logic                   busy
);

  localparam int BE_W   = be_w(DATA_W);
  localparam int WA_W   = wa_w(DEPTH);
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  logic            clr_we, ready, a_wr;
  logic [WA_W-1:0] clr_addr;

  bram_clear_seq #(.DEPTH(DEPTH), .CLEAR_EN(CLEAR_EN), .WA_W(WA_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  assign ready   = ~busy;
  assign a_ready = ready;
  assign b_ready = ready;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]                 acc, bad, rvalid, rerr;
  logic [1:0][ADDR_W-1:0]     addr;
  logic [1:0][WA_W-1:0]       idx;
  logic [1:0][DATA_W-1:0]     rdata;

  assign addr = {b_addr, a_addr};
  assign acc  = {b_req, a_req} & {2{ready}};
  assign a_wr = acc[0] & a_we & ~bad[0];

  // Clear owns the write port while busy; port A is not accepted then anyway.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < BE_W; i++)
        if (a_be[i]) mem[idx[0]][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [STAGES:1]             vld_pipe, err_pipe;
    logic [STAGES:1][DATA_W-1:0] dat_pipe;

    assign idx[p] = addr[p][WA_W+1:2];
    assign bad[p] = addr_bad(64'(addr[p]), WA_W);

    // Data stages only load on a valid so rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        err_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe[1] <= acc[p];
        if (acc[p]) begin
          dat_pipe[1] <= bad[p] ? '0 : mem[idx[p]];
          err_pipe[1] <= bad[p];
        end
        for (int s = 2; s <= STAGES; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          if (vld_pipe[s-1]) begin
            dat_pipe[s] <= dat_pipe[s-1];
            err_pipe[s] <= err_pipe[s-1];
          end
        end
      end
    end

    assign rvalid[p] = vld_pipe[STAGES];
    assign rdata[p]  = dat_pipe[STAGES];
    assign rerr[p]   = vld_pipe[STAGES] & err_pipe[STAGES];
  end

  assign a_rvalid = rvalid[0];
  assign a_rdata  = rdata[0];
  assign a_err    = rerr[0];
  assign b_rvalid = rvalid[1];
  assign b_rdata  = rdata[1];
  assign b_err    = rerr[1];

endmodule
